// File: rtl/pipe_pkg.sv
// Shared definitions for the P7 pipeline control slice: PC source
// encodings, sequencer state encoding and the default exception vector.
package pipe_pkg;

  // PC mux select driven by pipe_ctrl onto the PC register input mux.
  typedef enum logic [1:0] {
    PCSEL_SEQ = 2'b00,  // sequential / branch target from the datapath
    PCSEL_EXC = 2'b01,  // exception handler entry
    PCSEL_EPC = 2'b10   // return address held in CP0 EPC
  } pc_sel_e;

  // Exception-recovery sequencer states.
  typedef enum logic [1:0] {
    ST_RUN      = 2'b00,
    ST_EXC_HOLD = 2'b01
  } state_e;

  localparam logic [31:0] EXC_ENTRY_DEF = 32'h0000_4180;

  // True when an unsigned counter of width w can hold the value v.
  function automatic bit cnt_fits(input int v, input int w);
    return (v >= 0) && (v < (1 << w));
  endfunction

endpackage

// File: rtl/pipe_ctrl_md_counter.sv
// MDU busy counter: loads the operation latency when a MULT/DIV issues
// and counts down to zero, saturating there. busy is decoded straight from
// the register so it cannot glitch, and it drops the instant reset asserts.
module md_counter
  import pipe_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic is_div,
  output logic busy
);

  localparam logic [CNT_W-1:0] MULT_LD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LD  = CNT_W'(DIV_CYCLES);

  // Refuse to build with a counter too narrow for either latency; the
  // truncated load value would silently shorten the stall.
  if (!cnt_fits(MULT_CYCLES, CNT_W) || !cnt_fits(DIV_CYCLES, CNT_W)) begin : g_bad_cnt_w
    cnt_w_too_small_for_mdu_latency u_bad ();
  end

  logic [CNT_W-1:0] md_cnt;

  // Saturating decrement: a finished operation holds at zero, never wraps.
  function automatic logic [CNT_W-1:0] sat_dec(input logic [CNT_W-1:0] v);
    return (v == '0) ? '0 : v - CNT_W'(1);
  endfunction

  // Load on a new MDU issue, otherwise count the current operation down.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      md_cnt <= '0;
    end else if (load) begin
      md_cnt <= is_div ? DIV_LD : MULT_LD;
    end else begin
      md_cnt <= sat_dec(md_cnt);
    end
  end

  assign busy = (md_cnt != '0);

endmodule

// File: rtl/pipe_ctrl.sv
// Stall/flush sequencer for the five-stage P7 pipeline. Produces the PC
// write enable and source select plus the enable/clear controls of the
// F/D, D/E, E/M and M/W registers. All controls are combinational from the
// current inputs; only the exception-recovery state and the MDU counter are
// registered. Priority: exception entry, then stalls, then ERET, then run.
module pipe_ctrl
  import pipe_pkg::*;
#(
  parameter int          MULT_CYCLES = 5,
  parameter int          DIV_CYCLES  = 10,
  parameter int          CNT_W       = 4,
  parameter logic [31:0] EXC_ENTRY   = EXC_ENTRY_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        d_stall_req,
  input  logic        d_eret,
  input  logic        d_md_use,
  input  logic        e_md_start,
  input  logic        e_md_is_div,
  input  logic        exc_req,
  output logic        pc_en,
  output logic [1:0]  pc_sel,
  output logic [31:0] npc_exc,
  output logic        fd_en,
  output logic        fd_flush,
  output logic        de_flush,
  output logic        em_flush,
  output logic        mw_flush,
  output logic        md_busy
);

  state_e state;
  logic   exc_take;
  logic   md_go;
  logic   md_stall;
  logic   stall;

  // An exception is only taken from RUN; a request still asserted during
  // the hold cycle belongs to the instruction already being redirected.
  assign exc_take = exc_req & (state == ST_RUN);

  // An exception kills the MDU op issuing alongside it, but an operation
  // already counting keeps running so HI/LO is not left half-written.
  assign md_go = e_md_start & ~exc_take;

  // A HI/LO consumer in D must wait for a running op, and also for one
  // issuing in E this very cycle since the counter only loads at the edge.
  assign md_stall = d_md_use & (md_busy | e_md_start);
  assign stall    = d_stall_req | md_stall;

  assign npc_exc = EXC_ENTRY;

  md_counter #(
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES),
    .CNT_W       (CNT_W)
  ) u_md_counter (
    .clk    (clk),
    .reset  (reset),
    .load   (md_go),
    .is_div (e_md_is_div),
    .busy   (md_busy)
  );

  // Exception-recovery sequencer: one hold cycle after every exception entry.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_RUN;
    end else begin
      case (state)
        ST_RUN:      if (exc_req) state <= ST_EXC_HOLD;
        ST_EXC_HOLD: state <= ST_RUN;
        default:     state <= ST_RUN;
      endcase
    end
  end

  // Priority mux for the pipeline register and PC controls.
  always_comb begin
    pc_en    = 1'b1;
    pc_sel   = PCSEL_SEQ;
    fd_en    = 1'b1;
    fd_flush = 1'b0;
    de_flush = 1'b0;
    em_flush = 1'b0;
    mw_flush = 1'b0;
    if (!reset) begin
      // Freeze the PC and hold every pipeline register cleared.
      pc_en    = 1'b0;
      fd_en    = 1'b0;
      fd_flush = 1'b1;
      de_flush = 1'b1;
      em_flush = 1'b1;
      mw_flush = 1'b1;
    end else if (exc_take) begin
      // Redirect to the handler and squash everything younger than M,
      // including M itself; an ERET or stall in the same cycle is dropped.
      pc_sel   = PCSEL_EXC;
      fd_flush = 1'b1;
      de_flush = 1'b1;
      em_flush = 1'b1;
      mw_flush = 1'b1;
    end else if (stall) begin
      // Hold F and D in place and send a bubble down into E. A pending
      // ERET simply stays in D until the stall clears.
      pc_en    = 1'b0;
      fd_en    = 1'b0;
      de_flush = 1'b1;
    end else if (d_eret) begin
      // Jump to EPC and kill the instruction fetched behind the ERET;
      // ERET has no delay slot.
      pc_sel   = PCSEL_EPC;
      fd_flush = 1'b1;
    end
  end

endmodule
